// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit that sits beside the EX-stage ALU.
// It executes mult, multu, div and divu into the architectural HI/LO registers,
// takes mthi/mtlo writes, and feeds hi/lo to mfhi/mflo.
// One shift-add or restoring shift-subtract step runs per cycle, so every op takes
// a fixed WIDTH+1 edges from the start edge to the done pulse.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op            request (sampled only when idle); op 00 mult, 01 multu, 10 div, 11 divu
//   rs_val, rt_val       multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wr_data  direct HI/LO writes, honoured only when idle without start
//   busy                 operation in flight
//   done, div_zero       single-cycle result pulses
//   hi, lo               architectural HI/LO registers
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               is_div, is_div_d;
    logic               neg_lo, neg_lo_d;   // negate product (mult) or quotient (div)
    logic               neg_hi, neg_hi_d;   // negate remainder (div only)
    logic               dz, dz_d;
    logic [WIDTH-1:0]   acc_hi, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo, acc_lo_d;
    logic [WIDTH-1:0]   mcand, mcand_d;     // multiplicand or divisor magnitude
    logic               busy_d, done_d, div_zero_d;
    logic [WIDTH-1:0]   hi_d, lo_d;

    // Operand magnitudes; the minimum signed value maps to itself, read as unsigned 2^(WIDTH-1)
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    assign rs_neg = ~op[0] & rs_val[WIDTH-1];
    assign rt_neg = ~op[0] & rt_val[WIDTH-1];
    assign rs_abs = rs_neg ? WIDTH'(WIDTH'(0) - rs_val) : rs_val;
    assign rt_abs = rt_neg ? WIDTH'(WIDTH'(0) - rt_val) : rt_val;

    // Multiply step: add multiplicand when multiplier LSB is set, then shift {carry,hi,lo} right
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    // Divide step: shift partial remainder left by one dividend bit, subtract divisor if it fits
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, mcand};
    assign rem_diff = WIDTH'(rem_sh - {1'b0, mcand});

    // Sign correction applied in FIX
    logic [PW-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_lo ? PW'(PW'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    assign quo_fix  = neg_lo ? WIDTH'(WIDTH'(0) - acc_lo) : acc_lo;
    assign rem_fix  = neg_hi ? WIDTH'(WIDTH'(0) - acc_hi) : acc_hi;

    // Next-state and datapath control
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        is_div_d   = is_div;
        neg_lo_d   = neg_lo;
        neg_hi_d   = neg_hi;
        dz_d       = dz;
        acc_hi_d   = acc_hi;
        acc_lo_d   = acc_lo;
        mcand_d    = mcand;
        busy_d     = busy;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi;
        lo_d       = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_lo_d = rs_neg ^ rt_neg;
                    neg_hi_d = rs_neg;
                    dz_d     = op[1] && (rt_val == '0);
                    acc_hi_d = '0;
                    acc_lo_d = rs_abs;
                    mcand_d  = rt_abs;
                    cnt_d    = CNT_W'(WIDTH - 1);
                    busy_d   = 1'b1;
                    state_d  = ITER;
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            ITER: begin
                if (is_div) begin
                    acc_hi_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo[WIDTH-2:0], rem_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
                cnt_d = cnt - CNT_W'(1);
                if (cnt == '0) state_d = FIX;
            end
            FIX: begin
                if (!is_div) begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (!dz) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                div_zero_d = is_div & dz;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            is_div   <= is_div_d;
            neg_lo   <= neg_lo_d;
            neg_hi   <= neg_hi_d;
            dz       <= dz_d;
            acc_hi   <= acc_hi_d;
            acc_lo   <= acc_lo_d;
            mcand    <= mcand_d;
            busy     <= busy_d;
            done     <= done_d;
            div_zero <= div_zero_d;
            hi       <= hi_d;
            lo       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32): directed table, randomized
// ops against an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_mips_muldiv_unit;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  rs_val, rt_val, wr_data;
    logic          mthi, mtlo;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural meaning of each op
    function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l, output logic dz);
        logic [63:0] p;
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        dz = 1'b0;
        case (m_op)
            2'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                h  = p[63:32];
                l  = p[31:0];
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    qv = 64'(q);
                    rv = 64'(r);
                    l  = qv[31:0];
                    h  = rv[31:0];
                end
            end
            default: begin
                if (b == 32'd0) dz = 1'b1;
                else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Write HI then LO through mthi/mtlo (one cycle each)
    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; wr_data = h;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; wr_data = l;
        @(posedge clk); #1;
        mtlo = 1'b0;
        m_hi = h;
        m_lo = l;
    endtask

    // Issue one op from the current (post-edge) time and wait, bounded, for done
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_rs, input logic [31:0] t_rt,
                          output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                          output logic odz, output logic obusy);
        op = t_op; rs_val = t_rs; rt_val = t_rt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        ohi = hi; olo = lo; odz = div_zero; obusy = busy;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] ohi, olo, eh, el;
        logic odz, obusy, edz, saw;
        logic [1:0] r_op;
        logic [31:0] r_rs, r_rt;

        vecs[0]  = '{2'd0, 32'hFFFFFFFB, 32'h00000007, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{2'd3, 32'h00000064, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b1};
        vecs[6]  = '{2'd3, 32'h00000064, 32'h00000007, 32'hAAAAAAAA, 32'h55555555, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[7]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'hAAAAAAAA, 32'h55555555, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'd1, 32'h80000000, 32'h00000002, 32'hAAAAAAAA, 32'h55555555, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{2'd0, 32'h80000000, 32'h80000000, 32'hAAAAAAAA, 32'h55555555, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{2'd2, 32'h00000000, 32'h00000005, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 32'h00000000, 1'b0};
        vecs[11] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000001, 32'h00000002, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // mthi and mtlo together write both registers
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0F0F0F0F;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_both_hi", 64'(hi), 64'h0F0F0F0F);
        check("mthi_mtlo_both_lo", 64'(lo), 64'h0F0F0F0F);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            check($sformatf("v%0d_pre_hi", i), 64'(hi), 64'(vecs[i].pre_hi));
            check($sformatf("v%0d_pre_lo", i), 64'(lo), 64'(vecs[i].pre_lo));
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, ohi, olo, odz, obusy);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("v%0d_hi", i), 64'(ohi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(olo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_div_zero", i), 64'(odz), 64'(vecs[i].exp_dz));
            check($sformatf("v%0d_busy_at_done", i), 64'(obusy), 64'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("v%0d_dz_pulse", i), 64'(div_zero), 64'd0);
        end

        // Randomized ops, issued back to back (each start lands in the previous done cycle)
        preload(32'h13579BDF, 32'h2468ACE0);
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: r_rs = 32'h80000000;
                1: r_rs = 32'($urandom_range(0, 20));
                default: r_rs = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: r_rt = 32'd0;
                1: r_rt = 32'($urandom_range(1, 15));
                2: r_rt = 32'hFFFFFFFF;
                3: r_rt = 32'h80000000;
                default: r_rt = $urandom;
            endcase
            eh = m_hi; el = m_lo;
            model(r_op, r_rs, r_rt, eh, el, edz);
            run_op(r_op, r_rs, r_rt, lat, ohi, olo, odz, obusy);
            check($sformatf("rnd%0d_op%0d_latency", i, r_op), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_op%0d_%h_%h_hi", i, r_op, r_rs, r_rt), 64'(ohi), 64'(eh));
            check($sformatf("rnd%0d_op%0d_%h_%h_lo", i, r_op, r_rs, r_rt), 64'(olo), 64'(el));
            check($sformatf("rnd%0d_div_zero", i), 64'(odz), 64'(edz));
            m_hi = eh; m_lo = el;
        end
        @(posedge clk); #1;

        // start while busy is ignored; operand changes mid-op have no effect
        eh = m_hi; el = m_lo;
        model(2'd0, 32'd1234, 32'hFFFFFFF0, eh, el, edz);
        op = 2'd0; rs_val = 32'd1234; rt_val = 32'hFFFFFFF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                start = 1'b1; op = 2'd3; rs_val = 32'h55; rt_val = 32'h3;
            end else if (lat == 6) begin
                start = 1'b0;
            end
            if (done) break;
        end
        check("ignore_start_latency", 64'(lat), 64'(LAT));
        check("ignore_start_hi", 64'(hi), 64'(eh));
        check("ignore_start_lo", 64'(lo), 64'(el));
        @(posedge clk); #1;
        check("ignore_start_no_second_op", 64'(busy), 64'd0);

        // mthi while busy is dropped (divide-by-zero leaves HI/LO alone)
        preload(32'hA5A5A5A5, 32'h5A5A5A5A);
        op = 2'd3; rs_val = 32'h64; rt_val = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin
                mthi = 1'b1; wr_data = 32'hDEADBEEF;
            end else if (lat == 4) begin
                mthi = 1'b0;
                check("mthi_busy_mid_hi", 64'(hi), 64'hA5A5A5A5);
            end
            if (done) break;
        end
        check("mthi_busy_latency", 64'(lat), 64'(LAT));
        check("mthi_busy_div_zero", 64'(div_zero), 64'd1);
        check("mthi_busy_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthi_busy_lo", 64'(lo), 64'h5A5A5A5A);
        @(posedge clk); #1;

        // start has priority over mtlo in the same idle cycle
        preload(32'h22222222, 32'h11111111);
        op = 2'd1; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        mtlo = 1'b1; wr_data = 32'hCAFEBABE;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        check("start_mtlo_lo_kept", 64'(lo), 64'h11111111);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check("start_mtlo_latency", 64'(lat), 64'(LAT));
        check("start_mtlo_hi", 64'(hi), 64'h0);
        check("start_mtlo_lo", 64'(lo), 64'hC);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divu
        preload(32'h77777777, 32'h88888888);
        op = 2'd3; rs_val = 32'd1000; rt_val = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        check("midreset_no_stale_done", 64'(saw), 64'd0);

        run_op(2'd1, 32'd6, 32'd7, lat, ohi, olo, odz, obusy);
        check("post_reset_latency", 64'(lat), 64'(LAT));
        check("post_reset_hi", 64'(ohi), 64'd0);
        check("post_reset_lo", 64'(olo), 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
